// File: rtl/dz_tx_scanner_if.sv
// Signal bundle between the DZ11 transmit scanner, the CSR/TCR/TDR bus side and the UARTs.
// The scanner attaches to the slave modport; the bus/UART side attaches to the master modport.
interface dz_tx_scanner_if;
    logic        csrMSE;
    logic        csrTIE;
    logic [15:0] regTCR;
    logic [7:0]  uartTXEMPTY;
    logic        tdrWRITE;
    logic        devLOBYTE;
    logic [35:0] dzDATAI;
    logic        csrTRDY;
    logic [2:0]  csrTLINE;
    logic        txINTR;
    logic [7:0]  uartTXLOAD;
    logic [7:0]  uartTXDATA;

    modport master (
        output csrMSE, csrTIE, regTCR, uartTXEMPTY, tdrWRITE, devLOBYTE, dzDATAI,
        input  csrTRDY, csrTLINE, txINTR, uartTXLOAD, uartTXDATA
    );

    modport slave (
        input  csrMSE, csrTIE, regTCR, uartTXEMPTY, tdrWRITE, devLOBYTE, dzDATAI,
        output csrTRDY, csrTLINE, txINTR, uartTXLOAD, uartTXDATA
    );
endinterface

// File: rtl/dz_tx_scanner.sv
// DZ11 transmit scanner: round-robin search for an enabled, empty UART transmitter,
// reports it through CSR[TRDY]/CSR[TLINE] and forwards the next TDR low-byte write to it.
module dz_tx_scanner #(
    parameter int unsigned SCAN_DIV = 1
) (
    input logic            clk,
    input logic            rst,
    input logic            devRESET,
    input logic            csrCLR,
    dz_tx_scanner_if.slave bus
);

    localparam logic [7:0] DivLast = 8'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StReady
    } state_e;

    state_e     state_q;
    logic [2:0] ptr_q;
    logic [7:0] div_q;
    logic       trdy_q;
    logic [2:0] tline_q;
    logic [7:0] load_q;
    logic [7:0] data_q;

    logic       any_reset;
    logic [7:0] lin;
    logic       line_ok;
    logic       div_done;
    logic       lo_write;
    logic       unused_bits;

    assign any_reset = rst | devRESET | csrCLR;
    assign lin       = bus.regTCR[7:0];
    assign line_ok   = lin[ptr_q] & bus.uartTXEMPTY[ptr_q];
    assign div_done  = (div_q == DivLast);
    assign lo_write  = bus.tdrWRITE & bus.devLOBYTE;

    // DTR half of TCR and the upper data bits belong to other blocks.
    assign unused_bits = ^{bus.regTCR[15:8], bus.dzDATAI[35:8]};

    always_ff @(posedge clk) begin
        if (any_reset) begin
            state_q <= StIdle;
            ptr_q   <= 3'd0;
            div_q   <= 8'd0;
            trdy_q  <= 1'b0;
            tline_q <= 3'd0;
            load_q  <= 8'd0;
            data_q  <= 8'd0;
        end else begin
            load_q <= 8'd0;
            if (!bus.csrMSE) begin
                // Pointer and reported line survive a scan disable.
                state_q <= StIdle;
                trdy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        state_q <= StScan;
                        div_q   <= 8'd0;
                    end
                    StScan: begin
                        if (div_done) begin
                            div_q <= 8'd0;
                            if (line_ok) begin
                                tline_q <= ptr_q;
                                trdy_q  <= 1'b1;
                                state_q <= StReady;
                            end else begin
                                ptr_q <= ptr_q + 3'd1;
                            end
                        end else begin
                            div_q <= div_q + 8'd1;
                        end
                    end
                    StReady: begin
                        // A write beats a same-cycle line-enable clear.
                        if (lo_write) begin
                            load_q  <= 8'b0000_0001 << tline_q;
                            data_q  <= bus.dzDATAI[7:0];
                            trdy_q  <= 1'b0;
                            ptr_q   <= tline_q + 3'd1;
                            div_q   <= 8'd0;
                            state_q <= StScan;
                        end else if (!lin[tline_q]) begin
                            trdy_q  <= 1'b0;
                            ptr_q   <= tline_q + 3'd1;
                            div_q   <= 8'd0;
                            state_q <= StScan;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        trdy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.csrTRDY    = trdy_q;
    assign bus.csrTLINE   = tline_q;
    assign bus.txINTR     = trdy_q & bus.csrTIE;
    assign bus.uartTXLOAD = load_q;
    assign bus.uartTXDATA = data_q;

    a_load_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(load_q));
    a_trdy_ready  : assert property (@(posedge clk) disable iff (rst)
                                     trdy_q |-> (state_q == StReady));
    a_load_clears : assert property (@(posedge clk) disable iff (rst)
                                     (load_q != 8'd0) |-> !trdy_q);
    a_ptr_frozen  : assert property (@(posedge clk) disable iff (rst)
                                     trdy_q |-> (ptr_q == tline_q));

endmodule
